// File: rtl/data_sram_responder.sv
// data_sram_responder
// Target end of the CPU data_sram interface. Serves a word-addressed RAM
// and a small MMIO window (LED, number display, switch input and, when
// SRAM_RESP_TIMER_EN is defined, a free-running timer with compare IRQ).
// Read data is registered and appears the cycle after the request; the
// returned word is always the value from before that edge's write.
//
// Build option: define SRAM_RESP_TIMER_EN to implement TIMER, COMPARE and
// IRQ_STATUS. Without it those offsets read 0, ignore writes and timer_irq
// is tied low.
//
// Ports:
//   clk              system clock, rising edge
//   resetn           asynchronous active-low reset
//   data_sram_en     request valid this cycle
//   data_sram_wen    byte-lane write enables (0 = read)
//   data_sram_addr   byte address, bits [1:0] ignored for RAM
//   data_sram_wdata  write data
//   data_sram_rdata  registered read data
//   led              LED register
//   num_data         number-display register
//   switch           asynchronous switch inputs
//   timer_irq        timer compare interrupt, level
module data_sram_responder #(
    parameter int          ADDR_W       = 12,
    parameter logic [15:0] MMIO_BASE_HI = 16'hBFAF
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        data_sram_en,
    input  logic [3:0]  data_sram_wen,
    input  logic [31:0] data_sram_addr,
    input  logic [31:0] data_sram_wdata,
    output logic [31:0] data_sram_rdata,
    output logic [15:0] led,
    output logic [31:0] num_data,
    input  logic [7:0]  switch,
    output logic        timer_irq
);

    localparam logic [15:0] OFF_LED   = 16'hF000;
    localparam logic [15:0] OFF_NUM   = 16'hF010;
    localparam logic [15:0] OFF_SW    = 16'hF020;
`ifdef SRAM_RESP_TIMER_EN
    localparam logic [15:0] OFF_TIMER = 16'hE000;
    localparam logic [15:0] OFF_CMP   = 16'hE004;
    localparam logic [15:0] OFF_IRQ   = 16'hE008;
`endif

    function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                               input logic [31:0] new_v,
                                               input logic [3:0]  lanes);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) r[8*i +: 8] = new_v[8*i +: 8];
        end
        return r;
    endfunction

    logic [31:0]       mem [2**ADDR_W];
    logic              is_mmio;
    logic [15:0]       offset;
    logic [ADDR_W-1:0] word_idx;
    logic              wr;
    logic              mmio_wr;
    logic [31:0]       mmio_rd;

    logic [7:0]  sw_meta;
    logic [7:0]  sw_sync;
    logic [15:0] led_q;
    logic [31:0] num_q;

    assign is_mmio  = (data_sram_addr[31:16] == MMIO_BASE_HI);
    assign offset   = data_sram_addr[15:0];
    assign word_idx = data_sram_addr[ADDR_W+1:2];
    assign wr       = data_sram_en && (data_sram_wen != 4'b0000);
    assign mmio_wr  = wr && is_mmio;

    // RAM contents are deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr && !is_mmio) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wen[i]) mem[word_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sw_meta <= '0;
            sw_sync <= '0;
            led_q   <= '0;
            num_q   <= '0;
        end else begin
            sw_meta <= switch;
            sw_sync <= sw_meta;
            if (mmio_wr && offset == OFF_LED) begin
                // Only the low two lanes map onto the 16-bit LED register.
                if (data_sram_wen[0]) led_q[7:0]  <= data_sram_wdata[7:0];
                if (data_sram_wen[1]) led_q[15:8] <= data_sram_wdata[15:8];
            end
            if (mmio_wr && offset == OFF_NUM)
                num_q <= lane_merge(num_q, data_sram_wdata, data_sram_wen);
        end
    end

`ifdef SRAM_RESP_TIMER_EN
    logic [31:0] timer_q;
    logic [31:0] compare_q;
    logic        irq_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            timer_q   <= '0;
            compare_q <= 32'hFFFF_FFFF;
            irq_q     <= 1'b0;
        end else begin
            // A software load replaces the tick for that cycle.
            if (mmio_wr && offset == OFF_TIMER)
                timer_q <= lane_merge(timer_q, data_sram_wdata, data_sram_wen);
            else
                timer_q <= timer_q + 32'd1;
            if (mmio_wr && offset == OFF_CMP)
                compare_q <= lane_merge(compare_q, data_sram_wdata, data_sram_wen);
            // Set has priority over a simultaneous W1C.
            if (timer_q == compare_q)
                irq_q <= 1'b1;
            else if (mmio_wr && offset == OFF_IRQ && data_sram_wen[0] && data_sram_wdata[0])
                irq_q <= 1'b0;
        end
    end

    assign timer_irq = irq_q;
`else
    assign timer_irq = 1'b0;
`endif

    always_comb begin
        mmio_rd = '0;
        case (offset)
            OFF_LED:   mmio_rd = {16'b0, led_q};
            OFF_NUM:   mmio_rd = num_q;
            OFF_SW:    mmio_rd = {24'b0, sw_sync};
`ifdef SRAM_RESP_TIMER_EN
            OFF_TIMER: mmio_rd = timer_q;
            OFF_CMP:   mmio_rd = compare_q;
            OFF_IRQ:   mmio_rd = {31'b0, irq_q};
`endif
            default:   mmio_rd = '0;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_sram_rdata <= '0;
        end else if (data_sram_en) begin
            data_sram_rdata <= is_mmio ? mmio_rd : mem[word_idx];
        end
    end

    assign led      = led_q;
    assign num_data = num_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Testbench for data_sram_responder: directed scenarios plus randomized RAM
// traffic, checked against an address-map / lane-merge reference model.
module tb_data_sram_responder;

    logic        clk;
    logic        resetn;
    logic        en;
    logic [3:0]  wen;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic [15:0] led;
    logic [31:0] num_data;
    logic [7:0]  switch;
    logic        timer_irq;

`ifdef SRAM_RESP_TIMER_EN
    localparam bit TIMER_ON = 1'b1;
`else
    localparam bit TIMER_ON = 1'b0;
`endif

    localparam logic [31:0] A_LED   = 32'hBFAF_F000;
    localparam logic [31:0] A_NUM   = 32'hBFAF_F010;
    localparam logic [31:0] A_SW    = 32'hBFAF_F020;
    localparam logic [31:0] A_TIMER = 32'hBFAF_E000;
    localparam logic [31:0] A_CMP   = 32'hBFAF_E004;
    localparam logic [31:0] A_IRQ   = 32'hBFAF_E008;

    data_sram_responder dut (
        .clk             (clk),
        .resetn          (resetn),
        .data_sram_en    (en),
        .data_sram_wen   (wen),
        .data_sram_addr  (addr),
        .data_sram_wdata (wdata),
        .data_sram_rdata (rdata),
        .led             (led),
        .num_data        (num_data),
        .switch          (switch),
        .timer_irq       (timer_irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state
    logic [31:0] mem_m [int];
    logic [31:0] cmp_m;
    logic [31:0] tm_val;
    int          tm_cyc;
    logic        irq_m;
    int          cyc;

    always @(posedge clk or negedge resetn) begin
        if (!resetn) cyc <= 0;
        else         cyc <= cyc + 1;
    end

    function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n,
                                          input logic [3:0] l);
        logic [31:0] r;
        r = o;
        for (int i = 0; i < 4; i++) if (l[i]) r[8*i +: 8] = n[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] timer_now();
        return tm_val + 32'(cyc - tm_cyc);
    endfunction

    function automatic int word_of(input logic [31:0] a);
        return int'(a[13:2]);
    endfunction

    // Issue one request at a negedge; returns at the following negedge with
    // the response sampled. Also advances the timer/irq model for that edge.
    task automatic req(input logic [3:0] w, input logic [31:0] a, input logic [31:0] d,
                       output logic [31:0] r);
        logic [31:0] pre_t;
        pre_t = timer_now();
        en = 1'b1; wen = w; addr = a; wdata = d;
        @(negedge clk);
        r = rdata;
        en = 1'b0; wen = 4'b0000;
        if (pre_t == cmp_m) irq_m = 1'b1;
        else if (a == A_IRQ && w[0] && d[0]) irq_m = 1'b0;
        if (a == A_TIMER && w != 0) begin
            tm_val = merge(pre_t, d, w);
            tm_cyc = cyc;
        end
        if (a == A_CMP && w != 0) cmp_m = merge(cmp_m, d, w);
    endtask

    task automatic idle(input int n);
        logic [31:0] pre_t;
        for (int i = 0; i < n; i++) begin
            pre_t = timer_now();
            @(negedge clk);
            if (pre_t == cmp_m) irq_m = 1'b1;
        end
    endtask

    task automatic model_reset();
        cmp_m  = 32'hFFFF_FFFF;
        tm_val = 32'h0;
        tm_cyc = 0;
        irq_m  = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] r;
        resetn = 1'b0; en = 1'b0; wen = 0; addr = 0; wdata = 0; switch = 8'h00;
        model_reset();
        repeat (2) @(negedge clk);
        n_tests++;
        if (rdata !== 32'h0 || led !== 16'h0 || num_data !== 32'h0 || timer_irq !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_outputs: rdata=%h led=%h num=%h irq=%b, want all 0",
                     rdata, led, num_data, timer_irq);
        end
        resetn = 1'b1;
        req(4'h0, A_CMP, 0, r);
        n_tests++;
        if (r !== (TIMER_ON ? 32'hFFFF_FFFF : 32'h0)) begin
            n_fail++; $display("FAIL reset_compare: got %h want %h", r, TIMER_ON ? 32'hFFFF_FFFF : 32'h0);
        end
        req(4'h0, A_IRQ, 0, r);
        n_tests++;
        if (r !== 32'h0) begin n_fail++; $display("FAIL reset_irq_status: got %h want 0", r); end
        req(4'h0, A_SW, 0, r);
        n_tests++;
        if (r !== 32'h0) begin n_fail++; $display("FAIL reset_switch: got %h want 0", r); end
    endtask

    task automatic test_byte_lane();
        logic [31:0] r;
        req(4'hF, 32'h0000_0010, 32'h1122_3344, r);
        mem_m[word_of(32'h10)] = 32'h1122_3344;
        req(4'b0100, 32'h0000_0010, 32'hAABB_CCDD, r);
        mem_m[word_of(32'h10)] = merge(mem_m[word_of(32'h10)], 32'hAABB_CCDD, 4'b0100);
        req(4'h0, 32'h0000_0010, 0, r);
        n_tests++;
        if (r !== 32'h11BB_3344) begin
            n_fail++; $display("FAIL byte_lane: got %h want 11bb3344", r);
        end
    endtask

    task automatic test_read_before_write();
        logic [31:0] r;
        req(4'hF, 32'h0000_0040, 32'd5, r);
        req(4'hF, 32'h0000_0040, 32'd7, r);
        mem_m[word_of(32'h40)] = 32'd7;
        n_tests++;
        if (r !== 32'd5) begin n_fail++; $display("FAIL rbw_old: got %h want 5", r); end
        req(4'h0, 32'h0000_0040, 0, r);
        n_tests++;
        if (r !== 32'd7) begin n_fail++; $display("FAIL rbw_new: got %h want 7", r); end
        idle(3);
        n_tests++;
        if (rdata !== 32'd7) begin n_fail++; $display("FAIL rdata_hold: got %h want 7", rdata); end
    endtask

    task automatic test_mmio();
        logic [31:0] r;
        req(4'b0001, A_LED, 32'h1234_56A5, r);
        n_tests++;
        if (led !== 16'h00A5) begin n_fail++; $display("FAIL led_lane0: got %h want 00a5", led); end
        req(4'hF, A_LED, 32'hFFFF_1234, r);
        req(4'h0, A_LED, 0, r);
        n_tests++;
        if (r !== 32'h0000_1234 || led !== 16'h1234) begin
            n_fail++; $display("FAIL led_upper_ignored: rd=%h led=%h want 00001234", r, led);
        end
        req(4'hF, A_NUM, 32'hDEAD_BEEF, r);
        n_tests++;
        if (num_data !== 32'hDEAD_BEEF) begin
            n_fail++; $display("FAIL num_write: got %h want deadbeef", num_data);
        end
        req(4'b0010, A_NUM, 32'h0000_5500, r);
        req(4'h0, A_NUM, 0, r);
        n_tests++;
        if (r !== 32'hDEAD_55EF) begin n_fail++; $display("FAIL num_lane1: got %h want dead55ef", r); end
        switch = 8'h5A;
        idle(2);
        req(4'hF, A_SW, 32'hFFFF_FFFF, r);
        n_tests++;
        if (r !== 32'h0000_005A) begin n_fail++; $display("FAIL switch_read: got %h want 5a", r); end
        req(4'h0, A_SW, 0, r);
        n_tests++;
        if (r !== 32'h0000_005A) begin n_fail++; $display("FAIL switch_ro: got %h want 5a", r); end
        req(4'hF, 32'hBFAF_1230, 32'hCAFE_F00D, r);
        req(4'h0, 32'hBFAF_1230, 0, r);
        n_tests++;
        if (r !== 32'h0) begin n_fail++; $display("FAIL unmapped_read: got %h want 0", r); end
        // Restore LED to A5 for the reset scenario.
        req(4'b0011, A_LED, 32'h0000_00A5, r);
    endtask

    task automatic test_random_ram();
        logic [31:0] r, a, d, exp;
        logic [3:0]  w;
        int          idx;
        for (int i = 0; i < 16; i++) begin
            d = $urandom;
            req(4'hF, 32'h400 + 32'(4*i), d, r);
            mem_m[word_of(32'h400 + 32'(4*i))] = d;
        end
        for (int k = 0; k < 150; k++) begin
            a = $urandom;
            a = (a & 32'hFFFF_C003) | (32'h400 + 32'(4 * $urandom_range(0, 15)));
            if (a[31:16] == 16'hBFAF) a[31] = 1'b0;
            w = ($urandom_range(0, 2) == 0) ? 4'h0 : 4'($urandom);
            d = $urandom;
            idx = word_of(a);
            exp = mem_m[idx];
            req(w, a, d, r);
            mem_m[idx] = merge(mem_m[idx], d, w);
            n_tests++;
            if (r !== exp) begin
                n_fail++; $display("FAIL ram_random[%0d]: addr=%h got %h want %h", k, a, r, exp);
            end
            if ($urandom_range(0, 4) == 0) idle(1);
        end
    endtask

    task automatic test_timer();
        logic [31:0] r;
        int          first_rise;
        first_rise = 0;
        req(4'hF, A_CMP, 32'd20, r);
        req(4'hF, A_TIMER, 32'd10, r);
        for (int k = 1; k <= 14; k++) begin
            idle(1);
            if (timer_irq === 1'b1 && first_rise == 0) first_rise = k;
            n_tests++;
            if (timer_irq !== (TIMER_ON & irq_m)) begin
                n_fail++; $display("FAIL irq_level[%0d]: got %b want %b", k, timer_irq, TIMER_ON & irq_m);
            end
        end
        n_tests++;
        if (first_rise != (TIMER_ON ? 11 : 0)) begin
            n_fail++; $display("FAIL irq_rise_cycle: got %0d want %0d", first_rise, TIMER_ON ? 11 : 0);
        end
        req(4'h0, A_IRQ, 0, r);
        n_tests++;
        if (r !== (TIMER_ON ? 32'h1 : 32'h0)) begin
            n_fail++; $display("FAIL irq_status_read: got %h want %h", r, TIMER_ON ? 32'h1 : 32'h0);
        end
        req(4'hE, A_IRQ, 32'h1, r);
        n_tests++;
        if (timer_irq !== (TIMER_ON & irq_m)) begin
            n_fail++; $display("FAIL irq_w1c_needs_lane0: got %b want %b", timer_irq, TIMER_ON & irq_m);
        end
        req(4'h1, A_IRQ, 32'h1, r);
        n_tests++;
        if (timer_irq !== 1'b0 || irq_m !== 1'b0) begin
            n_fail++; $display("FAIL irq_clear: got %b want 0", timer_irq);
        end
    endtask

    task automatic test_timer_wrap();
        logic [31:0] r, exp;
        req(4'hF, A_TIMER, 32'hFFFF_FFFE, r);
        idle(2);
        exp = timer_now();
        req(4'h0, A_TIMER, 0, r);
        n_tests++;
        if (r !== (TIMER_ON ? exp : 32'h0) || exp !== 32'h0) begin
            n_fail++; $display("FAIL timer_wrap: got %h want %h", r, TIMER_ON ? exp : 32'h0);
        end
        exp = timer_now();
        req(4'h0, A_TIMER, 0, r);
        n_tests++;
        if (r !== (TIMER_ON ? exp : 32'h0)) begin
            n_fail++; $display("FAIL timer_b2b: got %h want %h", r, TIMER_ON ? exp : 32'h0);
        end
        exp = timer_now();
        req(4'b0010, A_TIMER, 32'h0000_AB00, r);
        tm_val = merge(exp, 32'h0000_AB00, 4'b0010);
        idle(3);
        exp = timer_now();
        req(4'h0, A_TIMER, 0, r);
        n_tests++;
        if (r !== (TIMER_ON ? exp : 32'h0)) begin
            n_fail++; $display("FAIL timer_lane_load: got %h want %h", r, TIMER_ON ? exp : 32'h0);
        end
    endtask

    task automatic test_async_reset();
        logic [31:0] r;
        req(4'h0, A_LED, 0, r);
        n_tests++;
        if (r !== 32'h0000_00A5 || led !== 16'h00A5) begin
            n_fail++; $display("FAIL pre_reset_led: rd=%h led=%h want a5", r, led);
        end
        en = 1'b1; wen = 4'b0001; addr = A_LED; wdata = 32'h0000_005A;
        #2 resetn = 1'b0;
        #1;
        n_tests++;
        if (led !== 16'h0 || rdata !== 32'h0 || num_data !== 32'h0 || timer_irq !== 1'b0) begin
            n_fail++; $display("FAIL async_reset: led=%h rdata=%h num=%h irq=%b want 0",
                               led, rdata, num_data, timer_irq);
        end
        en = 1'b0; wen = 4'b0000;
        @(negedge clk);
        resetn = 1'b1;
        model_reset();
        req(4'h0, 32'h0000_0010, 0, r);
        n_tests++;
        if (r !== mem_m[word_of(32'h10)]) begin
            n_fail++; $display("FAIL ram_survives_reset: got %h want %h", r, mem_m[word_of(32'h10)]);
        end
        req(4'h0, A_LED, 0, r);
        n_tests++;
        if (r !== 32'h0) begin n_fail++; $display("FAIL led_after_reset: got %h want 0", r); end
    endtask

    initial begin
        resetn = 1'b0;
        @(negedge clk);
        test_reset();
        test_byte_lane();
        test_read_before_write();
        test_mmio();
        test_random_ram();
        test_timer();
        test_timer_wrap();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
